// File: rtl/zanagotchi_atributos_n.sv
// rtl/zanagotchi_atributos_n.sv - saturating attribute engine with game tick, pause, alerts and death latch
module zanagotchi_atributos_n #(
    parameter int N_ATTR     = 3,
    parameter int W          = 8,
    parameter int TICK_DIV   = 100,
    parameter int INIT       = 100,
    parameter int GANHO      = 10,
    parameter int DECAIMENTO = 1,
    parameter int LIMIAR     = 20,
    localparam int IW        = (N_ATTR > 1) ? $clog2(N_ATTR) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                acao_valida,
    input  logic [IW-1:0]       acao_idx,
    input  logic                pausa,
    output logic [N_ATTR*W-1:0] atributos,
    output logic [N_ATTR-1:0]   alerta,
    output logic                morreu,
    output logic                tick
);

    localparam int            CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(TICK_DIV - 1);
    localparam logic [W:0]    MAX_VAL = {1'b0, {W{1'b1}}};

    typedef enum logic [1:0] {VIVO, PAUSADO, MORTO} estado_t;

    estado_t       estado, estado_next;
    logic [CW-1:0] cnt;
    logic [W-1:0]  v      [N_ATTR];
    logic [W-1:0]  v_next [N_ATTR];
    logic [W:0]    soma   [N_ATTR];
    logic          run, wrap, any_zero;

    // Counting resumes the same cycle pausa drops, so a pause only shifts the phase.
    assign run  = (estado != MORTO) && !pausa;
    assign wrap = run && (cnt == LAST);

    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < N_ATTR; i++) begin
            soma[i] = {1'b0, v[i]} + (W+1)'(GANHO);
            if (acao_valida && (acao_idx == IW'(i))) begin
                v_next[i] = (soma[i] > MAX_VAL) ? {W{1'b1}} : soma[i][W-1:0];
            end else begin
                v_next[i] = (v[i] >= W'(DECAIMENTO)) ? v[i] - W'(DECAIMENTO) : '0;
            end
            if (v_next[i] == '0) begin
                any_zero = 1'b1;
            end
        end
    end

    always_comb begin
        estado_next = estado;
        case (estado)
            VIVO: begin
                if (pausa)                estado_next = PAUSADO;
                else if (wrap && any_zero) estado_next = MORTO;
            end
            PAUSADO: begin
                if (!pausa) estado_next = (wrap && any_zero) ? MORTO : VIVO;
            end
            MORTO:   estado_next = MORTO;
            default: estado_next = VIVO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= VIVO;
        end else begin
            estado <= estado_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
            for (int i = 0; i < N_ATTR; i++) begin
                v[i] <= W'(INIT);
            end
        end else begin
            tick <= wrap;
            if (run) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
            if (wrap) begin
                for (int i = 0; i < N_ATTR; i++) begin
                    v[i] <= v_next[i];
                end
            end
        end
    end

    assign morreu = (estado == MORTO);

    for (genvar g = 0; g < N_ATTR; g++) begin : g_out
        assign atributos[g*W +: W] = v[g];
        assign alerta[g]           = ({1'b0, v[g]} < (W+1)'(LIMIAR));
    end

endmodule

// File: tb/tb_zanagotchi_atributos_n.sv
// tb/tb_zanagotchi_atributos_n.sv - scoreboard bench for zanagotchi_atributos_n
module tb_zanagotchi_atributos_n;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        acao_valida = 1'b0;
    logic [1:0]  acao_idx = 2'd0;
    logic        pausa = 1'b0;
    logic [23:0] atributos;
    logic [2:0]  alerta;
    logic        morreu;
    logic        tick;

    always #5 clk = ~clk;

    zanagotchi_atributos_n #(
        .N_ATTR(3), .W(8), .TICK_DIV(TD), .INIT(100),
        .GANHO(10), .DECAIMENTO(1), .LIMIAR(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .acao_valida(acao_valida), .acao_idx(acao_idx),
        .pausa(pausa), .atributos(atributos), .alerta(alerta), .morreu(morreu), .tick(tick)
    );

    typedef struct packed {
        logic [23:0] a;
        logic [2:0]  al;
        logic        m;
    } exp_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   mv [3];
    bit   mdead;
    exp_t sb [$];

    function automatic exp_t model_pack();
        exp_t e;
        e.a  = {8'(mv[2]), 8'(mv[1]), 8'(mv[0])};
        e.al = {mv[2] < 20, mv[1] < 20, mv[0] < 20};
        e.m  = mdead;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mv[i] = 100;
        mdead = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; acao_valida = 1'b0; acao_idx = 2'd0; pausa = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        repeat (20) begin
            @(negedge clk);
            cyc++;
            if (tick === 1'b1) return;
        end
        n_checks++; n_fail++;
        $display("FAIL tick_timeout: no tick within %0d cycles, required one", cyc);
        cyc = -1;
    endtask

    task automatic tick_step(input bit v, input logic [1:0] idx, input int exp_cyc, input string tag);
        int   cyc;
        exp_t e;
        acao_valida = v;
        acao_idx    = idx;
        for (int i = 0; i < 3; i++) begin
            if (v && idx == 2'(i)) mv[i] = (mv[i] + 10 > 255) ? 255 : mv[i] + 10;
            else                   mv[i] = (mv[i] >= 1) ? mv[i] - 1 : 0;
            if (mv[i] == 0) mdead = 1'b1;
        end
        sb.push_back(model_pack());
        wait_tick(cyc);
        e = sb.pop_front();
        if (cyc >= 0) begin
            n_checks++;
            if (cyc !== exp_cyc) begin
                n_fail++;
                $display("FAIL %s tick_period: got %0d cycles, required %0d", tag, cyc, exp_cyc);
            end
            n_checks++;
            if (atributos !== e.a) begin
                n_fail++;
                $display("FAIL %s atributos: got %h, required %h", tag, atributos, e.a);
            end
            n_checks++;
            if (alerta !== e.al) begin
                n_fail++;
                $display("FAIL %s alerta: got %b, required %b", tag, alerta, e.al);
            end
            n_checks++;
            if (morreu !== e.m) begin
                n_fail++;
                $display("FAIL %s morreu: got %b, required %b", tag, morreu, e.m);
            end
        end
    endtask

    task automatic check_idle(input logic [23:0] ea, input logic em, input string tag);
        n_checks++;
        if (tick !== 1'b0 || atributos !== ea || morreu !== em) begin
            n_fail++;
            $display("FAIL %s: got tick=%b atributos=%h morreu=%b, required tick=0 atributos=%h morreu=%b",
                     tag, tick, atributos, morreu, ea, em);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (atributos !== 24'h646464 || morreu !== 1'b0 || alerta !== 3'b000 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got atributos=%h morreu=%b alerta=%b tick=%b, required 646464/0/000/0",
                     atributos, morreu, alerta, tick);
        end
        do_reset();
        tick_step(1'b0, 2'd0, TD, "reset_first_tick");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle(24'h646464, 1'b0, "reset_async_mid_tick");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick_step(1'b0, 2'd0, TD, "reset_after_async");
    endtask

    task automatic test_idle_and_activity();
        do_reset();
        for (int t = 0; t < 3; t++) tick_step(1'b0, 2'd0, TD, "idle_decay");
        n_checks++;
        if (atributos !== 24'h616161) begin
            n_fail++;
            $display("FAIL idle_97: got %h, required 616161", atributos);
        end
        tick_step(1'b1, 2'd1, TD, "activity_idx1");
        tick_step(1'b1, 2'd1, TD, "activity_idx1");
        n_checks++;
        if (atributos !== {8'd95, 8'd117, 8'd95}) begin
            n_fail++;
            $display("FAIL activity_117: got %h, required %h", atributos, {8'd95, 8'd117, 8'd95});
        end
        tick_step(1'b1, 2'd3, TD, "activity_idx3");
        tick_step(1'b1, 2'd2, TD, "activity_idx2");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int t = 0; t < 20; t++) tick_step(1'b1, 2'd0, TD, "saturation");
        n_checks++;
        if (atributos[7:0] !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation_255: got %0d, required 255", atributos[7:0]);
        end
    endtask

    task automatic test_pause();
        do_reset();
        repeat (2) @(negedge clk);
        pausa = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_idle(24'h646464, 1'b0, "pause_hold");
        end
        pausa = 1'b0;
        tick_step(1'b0, 2'd0, TD - 2, "pause_resume");
        repeat (TD - 1) @(negedge clk);
        pausa = 1'b1;
        @(negedge clk);
        check_idle({8'd99, 8'd99, 8'd99}, 1'b0, "pause_at_wrap");
        pausa = 1'b0;
        tick_step(1'b0, 2'd0, 1, "pause_wrap_resume");
    endtask

    task automatic test_death();
        do_reset();
        for (int t = 0; t < 100; t++) tick_step(1'b0, 2'd0, TD, "death_decay");
        n_checks++;
        if (morreu !== 1'b1 || atributos !== 24'h000000) begin
            n_fail++;
            $display("FAIL death_flag: got morreu=%b atributos=%h, required 1/000000", morreu, atributos);
        end
        acao_valida = 1'b1; acao_idx = 2'd0;
        repeat (12) begin
            @(negedge clk);
            check_idle(24'h000000, 1'b1, "death_frozen");
        end
        pausa = 1'b1;
        @(negedge clk);
        check_idle(24'h000000, 1'b1, "death_ignores_pausa");
        pausa = 1'b0; acao_valida = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_idle(24'h646464, 1'b0, "death_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick_step(1'b0, 2'd0, TD, "after_death_reset");
    endtask

    initial begin
        test_reset();
        test_idle_and_activity();
        test_saturation();
        test_pause();
        test_death();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
